// File: rtl/bcd_hex_display.sv
// bcd_hex_display: latches a packed BCD count and serially decodes it into seven-segment patterns, committing all digits at once
module bcd_hex_display #(
  parameter int NUM_DIGITS          = 6,
  parameter bit BLANK_LEADING_ZEROS = 1,
  parameter bit ACTIVE_LOW_SEGMENTS = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    update,
  input  logic [4*NUM_DIGITS-1:0] bcdValue,
  output logic                    ready,
  output logic [7*NUM_DIGITS-1:0] segmentsOut,
  output logic                    overflowError
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] POL = ACTIVE_LOW_SEGMENTS ? 7'h7F : 7'h00;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [7*NUM_DIGITS-1:0] r_work;
  logic [IW-1:0]           r_idx;
  logic                    r_blank;
  logic                    r_err;
  logic [3:0]              w_nib;
  logic                    w_bad;
  logic                    w_blank_digit;
  logic [6:0]              w_pat;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      default: decode = 7'h6F;
    endcase
  endfunction
  // Image of value 0: digit 0 always shows '0', higher digits depend on blanking
  function automatic logic [7*NUM_DIGITS-1:0] zero_image();
    zero_image = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      zero_image[7*i +: 7] = ((i == 0 || !BLANK_LEADING_ZEROS) ? 7'h3F : 7'h00) ^ POL;
  endfunction
  // Pattern for the digit under the current index; dash for invalid nibbles
  always_comb begin
    w_nib         = r_shadow[{r_idx, 2'b00} +: 4];
    w_bad         = w_nib > 4'd9;
    w_blank_digit = !w_bad && w_nib == 4'd0 && r_blank && r_idx != '0;
    w_pat         = (w_bad ? 7'h40 : w_blank_digit ? 7'h00 : decode(w_nib)) ^ POL;
  end
  // Capture / convert-one-digit-per-cycle / commit sequencer with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      ready         <= 1'b1;
      overflowError <= 1'b0;
      segmentsOut   <= zero_image();
      r_work        <= '0;
      r_shadow      <= '0;
      r_idx         <= '0;
      r_blank       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (update) begin
          r_shadow <= bcdValue;
          r_idx    <= IW'(NUM_DIGITS - 1);
          r_blank  <= BLANK_LEADING_ZEROS;
          r_err    <= 1'b0;
          ready    <= 1'b0;
          r_state  <= CONVERT;
        end
        CONVERT: begin
          r_work[7*r_idx +: 7] <= w_pat;
          r_err                <= r_err | w_bad;
          r_blank              <= w_blank_digit;
          if (r_idx == '0) r_state <= COMMIT;
          else r_idx <= r_idx - 1'b1;
        end
        COMMIT: begin
          segmentsOut   <= r_work;
          overflowError <= r_err;
          ready         <= 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
